// File: rtl/commit_dests_if.sv
// Memory write port used by commit_dests to retire memory destinations.
// The master drives valid/addr/data/strb; the slave returns ready.
interface commit_dests_if;
   logic        mem_wr_valid;
   logic        mem_wr_ready;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_strb;

   modport master (output mem_wr_valid, output mem_wr_addr, output mem_wr_data,
                   output mem_wr_strb, input mem_wr_ready);
   modport slave  (input mem_wr_valid, input mem_wr_addr, input mem_wr_data,
                   input mem_wr_strb, output mem_wr_ready);
endinterface

// File: rtl/commit_dests.sv
// Writeback stage: retires register destinations into the GPR file and memory destinations over a write port.
// Optional macro COMMIT_BYTE_REGS_EN enables x86 8-bit register encoding (AL..BL, AH..BH) for byte writes.
module commit_dests #(
   parameter logic [31:0] RESET_ESP = 32'h0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             dest0_kind,
   input  logic [1:0]             dest1_kind,
   input  logic [31:0]            dest0_sel,
   input  logic [31:0]            dest1_sel,
   input  logic [31:0]            dest0_val,
   input  logic [31:0]            dest1_val,
   input  logic                   reg_1byte,
   input  logic                   prefix_operand_16bit,
   commit_dests_if.master         mem,
   output logic [31:0]            eax,
   output logic [31:0]            ecx,
   output logic [31:0]            edx,
   output logic [31:0]            ebx,
   output logic [31:0]            esp,
   output logic [31:0]            ebp,
   output logic [31:0]            esi,
   output logic [31:0]            edi,
   output logic                   commit_done,
   output logic                   err_kind
);
   typedef enum logic [1:0] {IDLE = 2'd0, MEM0 = 2'd1, MEM1 = 2'd2} state_e;
   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_WORD = 2'd1, SZ_DWORD = 2'd2} size_e;

   localparam logic [1:0] K_REG = 2'b01;
   localparam logic [1:0] K_MEM = 2'b10;
   localparam logic [1:0] K_ILL = 2'b11;

   state_e      state_q, state_d;
   size_e       size_q, size_d, reg_size_s;
   logic [1:0]  kind0_q, kind0_d, kind1_q, kind1_d;
   logic [31:0] sel0_q, sel0_d, sel1_q, sel1_d;
   logic [31:0] val0_q, val0_d, val1_q, val1_d;
   logic [31:0] gpr_q [8];
   logic [31:0] gpr_d [8];
   logic        done_q, done_d, err_q, err_d, rdy_q, rdy_d, wv_q, wv_d;
   logic [31:0] wa_q, wa_d, wd_q, wd_d;
   logic [3:0]  ws_q, ws_d;
   logic        accept_s, hi0_s, hi1_s;
   logic [2:0]  idx0_s, idx1_s;

   function automatic logic [31:0] fmt_data(input logic [31:0] v, input size_e sz);
      case (sz)
         SZ_BYTE: return {24'h000000, v[7:0]};
         SZ_WORD: return {16'h0000, v[15:0]};
         default: return v;
      endcase
   endfunction

   function automatic logic [3:0] fmt_strb(input size_e sz);
      case (sz)
         SZ_BYTE: return 4'b0001;
         SZ_WORD: return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // hi selects the AH..BH byte lane for byte writes
   function automatic logic [31:0] merge_reg(input logic [31:0] old, input logic [31:0] v,
                                             input size_e sz, input logic hi);
      case (sz)
         SZ_BYTE: return hi ? {old[31:16], v[7:0], old[7:0]} : {old[31:8], v[7:0]};
         SZ_WORD: return {old[31:16], v[15:0]};
         default: return v;
      endcase
   endfunction

   // Next-state, register-file update and registered output decode
   always_comb begin
      accept_s = in_valid && rdy_q;
      state_d  = state_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      for (int i = 0; i < 8; i++) gpr_d[i] = gpr_q[i];
`ifdef COMMIT_BYTE_REGS_EN
      reg_size_s = reg_1byte ? SZ_BYTE : (prefix_operand_16bit ? SZ_WORD : SZ_DWORD);
      idx0_s     = reg_1byte ? {1'b0, dest0_sel[1:0]} : dest0_sel[2:0];
      idx1_s     = reg_1byte ? {1'b0, dest1_sel[1:0]} : dest1_sel[2:0];
      hi0_s      = reg_1byte && dest0_sel[2];
      hi1_s      = reg_1byte && dest1_sel[2];
`else
      reg_size_s = prefix_operand_16bit ? SZ_WORD : SZ_DWORD;
      idx0_s     = dest0_sel[2:0];
      idx1_s     = dest1_sel[2:0];
      hi0_s      = 1'b0;
      hi1_s      = 1'b0;
`endif
      if (accept_s) begin
         kind0_d = dest0_kind;
         kind1_d = dest1_kind;
         sel0_d  = dest0_sel;
         sel1_d  = dest1_sel;
         val0_d  = dest0_val;
         val1_d  = dest1_val;
         size_d  = reg_1byte ? SZ_BYTE : (prefix_operand_16bit ? SZ_WORD : SZ_DWORD);
         err_d   = (dest0_kind == K_ILL) || (dest1_kind == K_ILL);
         // dest1 applied last so it wins a same-register conflict
         gpr_d[idx0_s] = (dest0_kind == K_REG) ?
                         merge_reg(gpr_d[idx0_s], dest0_val, reg_size_s, hi0_s) : gpr_d[idx0_s];
         gpr_d[idx1_s] = (dest1_kind == K_REG) ?
                         merge_reg(gpr_d[idx1_s], dest1_val, reg_size_s, hi1_s) : gpr_d[idx1_s];
      end else begin
         kind0_d = kind0_q;
         kind1_d = kind1_q;
         sel0_d  = sel0_q;
         sel1_d  = sel1_q;
         val0_d  = val0_q;
         val1_d  = val1_q;
         size_d  = size_q;
      end

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (dest0_kind == K_MEM) state_d = MEM0;
               else if (dest1_kind == K_MEM) state_d = MEM1;
               else done_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         MEM0: begin
            if (mem.mem_wr_ready) begin
               if (kind1_q == K_MEM) begin
                  state_d = MEM1;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = MEM0;
            end
         end
         MEM1: begin
            if (mem.mem_wr_ready) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = MEM1;
            end
         end
         default: state_d = IDLE;
      endcase

      rdy_d = (state_d == IDLE) && !done_d;
      wv_d  = (state_d != IDLE);
      case (state_d)
         MEM0: begin
            wa_d = sel0_d;
            wd_d = fmt_data(val0_d, size_d);
            ws_d = fmt_strb(size_d);
         end
         MEM1: begin
            wa_d = sel1_d;
            wd_d = fmt_data(val1_d, size_d);
            ws_d = fmt_strb(size_d);
         end
         default: begin
            wa_d = 32'h0;
            wd_d = 32'h0;
            ws_d = 4'b0000;
         end
      endcase
   end

   // State, latched request, GPRs and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         size_q  <= SZ_DWORD;
         kind0_q <= 2'b00;
         kind1_q <= 2'b00;
         sel0_q  <= 32'h0;
         sel1_q  <= 32'h0;
         val0_q  <= 32'h0;
         val1_q  <= 32'h0;
         for (int i = 0; i < 8; i++) gpr_q[i] <= (i == 4) ? RESET_ESP : 32'h0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b1;
         wv_q    <= 1'b0;
         wa_q    <= 32'h0;
         wd_q    <= 32'h0;
         ws_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         kind0_q <= kind0_d;
         kind1_q <= kind1_d;
         sel0_q  <= sel0_d;
         sel1_q  <= sel1_d;
         val0_q  <= val0_d;
         val1_q  <= val1_d;
         for (int i = 0; i < 8; i++) gpr_q[i] <= gpr_d[i];
         done_q  <= done_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
         wv_q    <= wv_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         ws_q    <= ws_d;
      end
   end

   assign in_ready         = rdy_q;
   assign mem.mem_wr_valid = wv_q;
   assign mem.mem_wr_addr  = wa_q;
   assign mem.mem_wr_data  = wd_q;
   assign mem.mem_wr_strb  = ws_q;
   assign commit_done      = done_q;
   assign err_kind         = err_q;
   assign eax = gpr_q[0];
   assign ecx = gpr_q[1];
   assign edx = gpr_q[2];
   assign ebx = gpr_q[3];
   assign esp = gpr_q[4];
   assign ebp = gpr_q[5];
   assign esi = gpr_q[6];
   assign edi = gpr_q[7];
endmodule
